reg_file_bypass: RTL and testbench

//   Architectural register file for the 5-stage pipeline. Consumer of the 4:16 write wordlines.
//   The decode stage reads two source registers. The writeback stage writes one destination register.
//   An internal one-hot write-wordline decode selects the target row.
//   A same-cycle write-to-read bypass returns writeback data to decode in the cycle it is written,
//   so no extra hazard stall is needed.

---
 rtl/reg_file_bypass.sv | 77 +++++++
 tb/tb_reg_file_bypass.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/reg_file_bypass.sv
// reg_file_bypass
//   Architectural register file for the 5-stage pipeline. Decode reads two
//   source registers combinationally. Writeback writes one destination
//   register through a one-hot write-wordline decode. A same-cycle
//   write-to-read bypass returns writeback data to decode in the cycle it is
//   written, so decode never stalls on a writeback hazard.
//
// Ports
//   clk       in   1       rising-edge clock
//   rst       in   1       synchronous reset, active-high; clears every row
//   SrcReg1   in   ADDR_W  read port 1 index
//   SrcReg2   in   ADDR_W  read port 2 index
//   DstReg    in   ADDR_W  writeback destination index
//   WriteReg  in   1       writeback write enable
//   DstData   in   DATA_W  writeback data
//   SrcData1  out  DATA_W  read port 1 data (bypassed when it matches DstReg)
//   SrcData2  out  DATA_W  read port 2 data (bypassed when it matches DstReg)
//
// R0 is ordinary storage, not hardwired to zero.
module reg_file_bypass #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SrcReg1,
  input  logic [ADDR_W-1:0] SrcReg2,
  input  logic [ADDR_W-1:0] DstReg,
  input  logic              WriteReg,
  input  logic [DATA_W-1:0] DstData,
  output logic [DATA_W-1:0] SrcData1,
  output logic [DATA_W-1:0] SrcData2
);

  // Row count is tied to the index width so the two can never disagree.
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] wordline;
  logic                write_live;

  // Reset discards a concurrent write, and also suppresses the bypass.
  assign write_live = WriteReg & ~rst;

  always_comb begin
    wordline = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      wordline[i] = write_live & (DstReg == ADDR_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wordline[i]) begin
          regs[i] <= DstData;
        end
      end
    end
  end

  always_comb begin
    SrcData1 = regs[SrcReg1];
    SrcData2 = regs[SrcReg2];
    if (write_live && (SrcReg1 == DstReg)) begin
      SrcData1 = DstData;
    end
    if (write_live && (SrcReg2 == DstReg)) begin
      SrcData2 = DstData;
    end
  end

endmodule

// File: tb/tb_reg_file_bypass.sv
// tb_reg_file_bypass
//   Directed vector table plus a randomized run against a reference array
//   model for reg_file_bypass. Inputs change on the falling edge; outputs are
//   sampled 1 time unit later, well before the next rising edge.
module tb_reg_file_bypass;

  logic        clk;
  logic        rst;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic [3:0]  DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [15:0] SrcData1;
  logic [15:0] SrcData2;

  reg_file_bypass #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .DstReg   (DstReg),
    .WriteReg (WriteReg),
    .DstData  (DstData),
    .SrcData1 (SrcData1),
    .SrcData2 (SrcData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [3:0]  dst;
    logic [15:0] dd;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        chk;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] model [16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic w, input logic [3:0] d,
                              input logic [15:0] dd, input logic [3:0] a, input logic [3:0] b,
                              input logic [15:0] e1, input logic [15:0] e2, input logic c);
    vec_t v;
    v.rst = r; v.wr = w; v.dst = d; v.dd = dd; v.s1 = a; v.s2 = b;
    v.e1 = e1; v.e2 = e2; v.chk = c;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [3:0]  r1, r2, rd;
    logic [15:0] rdat, e1, e2;
    logic        rr, rw;

    rst = 1'b0; WriteReg = 1'b0; DstReg = '0; DstData = '0; SrcReg1 = '0; SrcReg2 = '0;

    // Reset with a concurrent write to R3: first cycle rows are still X.
    add(1, 1, 4'd3, 16'hBEEF, 4'd3, 4'd3, 16'h0, 16'h0, 0);
    add(1, 1, 4'd3, 16'hBEEF, 4'd3, 4'd3, 16'h0000, 16'h0000, 1);
    for (int i = 0; i < 16; i++)
      add(0, 0, 4'd3, 16'hBEEF, 4'(i), 4'(15 - i), 16'h0000, 16'h0000, 1);

    // Write every row; port 1 sees the bypass, port 2 the next (unwritten) row.
    for (int i = 0; i < 16; i++)
      add(0, 1, 4'(i), 16'h1000 + 16'(i), 4'(i), 4'((i + 1) % 16),
          16'h1000 + 16'(i), (i == 15) ? 16'h1000 : 16'h0000, 1);
    for (int i = 0; i < 16; i++)
      add(0, 0, 4'd0, 16'h0, 4'(i), 4'(15 - i), 16'h1000 + 16'(i), 16'h100F - 16'(i), 1);

    // Bypass on port 1 only, then storage readback.
    add(0, 1, 4'd5, 16'h0005, 4'd5, 4'd6, 16'h0005, 16'h1006, 1);
    add(0, 1, 4'd5, 16'hA5A5, 4'd5, 4'd6, 16'hA5A5, 16'h1006, 1);
    add(0, 0, 4'd0, 16'h0000, 4'd5, 4'd5, 16'hA5A5, 16'hA5A5, 1);

    // Disabled write leaves R7 and outputs untouched.
    add(0, 0, 4'd7, 16'hFFFF, 4'd7, 4'd7, 16'h1007, 16'h1007, 1);
    add(0, 0, 4'd7, 16'hFFFF, 4'd7, 4'd7, 16'h1007, 16'h1007, 1);

    // Both ports on the bypassed index.
    add(0, 1, 4'd8, 16'h8888, 4'd8, 4'd8, 16'h8888, 16'h8888, 1);

    // Mid-stream reset with a write to R9: bypass suppressed, stored data shown.
    add(1, 1, 4'd9, 16'h9999, 4'd9, 4'd0, 16'h1009, 16'h1000, 1);
    for (int i = 0; i < 16; i++)
      add(0, 0, 4'd9, 16'h9999, 4'(i), 4'(15 - i), 16'h0000, 16'h0000, 1);

    // First write after reset.
    add(0, 1, 4'd9, 16'h1234, 4'd9, 4'd3, 16'h1234, 16'h0000, 1);
    add(0, 0, 4'd0, 16'h0000, 4'd9, 4'd9, 16'h1234, 16'h1234, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; WriteReg = vecs[i].wr; DstReg = vecs[i].dst;
      DstData = vecs[i].dd; SrcReg1 = vecs[i].s1; SrcReg2 = vecs[i].s2;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d port1", i), SrcData1, vecs[i].e1);
        check($sformatf("vec%0d port2", i), SrcData2, vecs[i].e2);
      end
    end

    // Randomized run; the first cycle resets so the model starts in sync.
    for (int c = 0; c < 10000; c++) begin
      rr   = (c == 0) || ($urandom_range(63) == 0);
      rw   = 1'($urandom_range(1));
      rd   = 4'($urandom);
      rdat = 16'($urandom);
      r1   = ($urandom_range(3) == 0) ? rd : 4'($urandom);
      r2   = ($urandom_range(3) == 0) ? rd : 4'($urandom);
      @(negedge clk);
      rst = rr; WriteReg = rw; DstReg = rd; DstData = rdat; SrcReg1 = r1; SrcReg2 = r2;
      #1;
      if (c != 0) begin
        e1 = (rw && !rr && r1 == rd) ? rdat : model[r1];
        e2 = (rw && !rr && r2 == rd) ? rdat : model[r2];
        check($sformatf("rand%0d port1", c), SrcData1, e1);
        check($sformatf("rand%0d port2", c), SrcData2, e2);
      end
      if (rr) begin
        for (int k = 0; k < 16; k++) model[k] = 16'h0000;
      end else if (rw) begin
        model[rd] = rdat;
      end
    end

    @(negedge clk);
    rst = 1'b0; WriteReg = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
